// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and matrix element indices for the 2x2 systolic feeder.
// Matrices are packed {X00,X01,X10,X11} with X00 in the most significant lane.
package systolic_pkg;

    localparam int SYS_DW     = 8;
    localparam int SYS_CW     = 15;
    localparam int FEED_SLOTS = 3;
    localparam int FLUSH_CYC  = 2;

    // Lane index of each element within a packed 2x2 matrix
    localparam int IDX_00 = 3;
    localparam int IDX_01 = 2;
    localparam int IDX_10 = 1;
    localparam int IDX_11 = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        FLUSH = 3'd3,
        HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/systolic_slot_sel.sv
// Maps a feed slot index and the latched matrices onto the four skewed operand streams.
// Outputs are zero when disabled or for any slot outside 0..2.
module systolic_slot_sel
    import systolic_pkg::*;
#(
    parameter int DW = SYS_DW
) (
    input  logic [1:0]      slot,
    input  logic            en,
    input  logic [4*DW-1:0] mat_a,
    input  logic [4*DW-1:0] mat_b,
    output logic [DW-1:0]   a1,
    output logic [DW-1:0]   b1,
    output logic [DW-1:0]   a2,
    output logic [DW-1:0]   b2
);

    // Row 2 and column 2 run one slot behind row 1 / column 1 to form the skew
    always_comb begin
        a1 = '0;
        b1 = '0;
        a2 = '0;
        b2 = '0;
        if (en) begin
            case (slot)
                2'd0: begin
                    a1 = mat_a[IDX_00*DW +: DW];
                    b1 = mat_b[IDX_00*DW +: DW];
                end
                2'd1: begin
                    a1 = mat_a[IDX_01*DW +: DW];
                    b1 = mat_b[IDX_10*DW +: DW];
                    a2 = mat_a[IDX_10*DW +: DW];
                    b2 = mat_b[IDX_01*DW +: DW];
                end
                2'd2: begin
                    a2 = mat_a[IDX_11*DW +: DW];
                    b2 = mat_b[IDX_11*DW +: DW];
                end
                default: begin
                    a1 = '0;
                    b1 = '0;
                    a2 = '0;
                    b2 = '0;
                end
            endcase
        end else begin
            a1 = '0;
            b1 = '0;
            a2 = '0;
            b2 = '0;
        end
    end

endmodule

// File: rtl/systolic_feeder_2x2.sv
// Operand sequencer and result reader for the 2x2 systolic multiplier (all outputs registered).
// Optional exact-overflow flag on res_ovf when SYSFEED_OVF_EN is defined; otherwise res_ovf is 0.
module systolic_feeder_2x2
    import systolic_pkg::*;
#(
    parameter int DW = SYS_DW,
    parameter int CW = SYS_CW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            start_ready,
    input  logic [4*DW-1:0] mat_a,
    input  logic [4*DW-1:0] mat_b,
    output logic            arr_clr_n,
    output logic [DW-1:0]   arr_a1,
    output logic [DW-1:0]   arr_a2,
    output logic [DW-1:0]   arr_b1,
    output logic [DW-1:0]   arr_b2,
    input  logic [CW-1:0]   c11,
    input  logic [CW-1:0]   c12,
    input  logic [CW-1:0]   c21,
    input  logic [CW-1:0]   c22,
    output logic [4*CW-1:0] res_c,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_ovf
);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [1:0]      cnt_r;
    logic [1:0]      cnt_nxt_s;
    logic [4*DW-1:0] mat_a_r;
    logic [4*DW-1:0] mat_b_r;
    logic            accept_s;
    logic            capture_s;
    logic [DW-1:0]   sel_a1_s;
    logic [DW-1:0]   sel_b1_s;
    logic [DW-1:0]   sel_a2_s;
    logic [DW-1:0]   sel_b2_s;

    assign accept_s  = start && start_ready;
    assign capture_s = (state_r == FLUSH) && (state_nxt_s == HOLD);

    // Next-state logic; cnt_r counts feed slots and then flush cycles
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = CLEAR;
                    cnt_nxt_s   = 2'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CLEAR: begin
                state_nxt_s = FEED;
                cnt_nxt_s   = 2'd0;
            end
            FEED: begin
                if (cnt_r == 2'(FEED_SLOTS - 1)) begin
                    state_nxt_s = FLUSH;
                    cnt_nxt_s   = 2'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 2'd1;
                end
            end
            FLUSH: begin
                if (cnt_r == 2'(FLUSH_CYC - 1)) begin
                    state_nxt_s = HOLD;
                    cnt_nxt_s   = 2'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 2'd1;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 2'd0;
            end
        endcase
    end

    // Operands are looked up for the slot the array will see next cycle
    systolic_slot_sel #(.DW(DW)) u_slot_sel (
        .slot  (cnt_nxt_s),
        .en    (state_nxt_s == FEED),
        .mat_a (mat_a_r),
        .mat_b (mat_b_r),
        .a1    (sel_a1_s),
        .b1    (sel_b1_s),
        .a2    (sel_a2_s),
        .b2    (sel_b2_s)
    );

    // State and slot counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Operand latch on job accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mat_a_r <= '0;
            mat_b_r <= '0;
        end else if (accept_s) begin
            mat_a_r <= mat_a;
            mat_b_r <= mat_b;
        end
    end

    // Array-facing outputs are decoded from the next state so they align with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_ready <= 1'b1;
            arr_clr_n   <= 1'b1;
            arr_a1      <= '0;
            arr_b1      <= '0;
            arr_a2      <= '0;
            arr_b2      <= '0;
        end else begin
            start_ready <= (state_nxt_s == IDLE);
            arr_clr_n   <= (state_nxt_s != CLEAR);
            arr_a1      <= sel_a1_s;
            arr_b1      <= sel_b1_s;
            arr_a2      <= sel_a2_s;
            arr_b2      <= sel_b2_s;
        end
    end

    // Result capture after the flush window; held until the consumer takes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_c     <= '0;
            res_valid <= 1'b0;
        end else if (capture_s) begin
            res_c     <= {c11, c12, c21, c22};
            res_valid <= 1'b1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

`ifdef SYSFEED_OVF_EN
    logic ovf_s;

    function automatic logic [2*DW:0] dot2(input logic [DW-1:0] x0, input logic [DW-1:0] y0,
                                           input logic [DW-1:0] x1, input logic [DW-1:0] y1);
        logic [2*DW:0] p0;
        logic [2*DW:0] p1;
        p0 = {{(DW+1){1'b0}}, x0} * {{(DW+1){1'b0}}, y0};
        p1 = {{(DW+1){1'b0}}, x1} * {{(DW+1){1'b0}}, y1};
        return p0 + p1;
    endfunction

    function automatic logic exceeds(input logic [2*DW:0] v);
        return |v[2*DW:CW];
    endfunction

    // Exact dot products from the latched operands, compared against the array range
    always_comb begin
        ovf_s = exceeds(dot2(mat_a_r[IDX_00*DW +: DW], mat_b_r[IDX_00*DW +: DW],
                             mat_a_r[IDX_01*DW +: DW], mat_b_r[IDX_10*DW +: DW]))
              | exceeds(dot2(mat_a_r[IDX_00*DW +: DW], mat_b_r[IDX_01*DW +: DW],
                             mat_a_r[IDX_01*DW +: DW], mat_b_r[IDX_11*DW +: DW]))
              | exceeds(dot2(mat_a_r[IDX_10*DW +: DW], mat_b_r[IDX_00*DW +: DW],
                             mat_a_r[IDX_11*DW +: DW], mat_b_r[IDX_10*DW +: DW]))
              | exceeds(dot2(mat_a_r[IDX_10*DW +: DW], mat_b_r[IDX_01*DW +: DW],
                             mat_a_r[IDX_11*DW +: DW], mat_b_r[IDX_11*DW +: DW]));
    end

    // Overflow flag travels with res_valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_ovf <= 1'b0;
        end else if (capture_s) begin
            res_ovf <= ovf_s;
        end else if (res_valid && res_ready) begin
            res_ovf <= 1'b0;
        end
    end
`else
    assign res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Self-checking bench for systolic_feeder_2x2 with a behavioural 2x2 systolic array attached.
// Results are compared against plain matrix arithmetic computed in the bench.
module tb_systolic_feeder_2x2;

    localparam int DW = 8;
    localparam int CW = 15;
`ifdef SYSFEED_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          start_ready;
    logic [31:0]   mat_a;
    logic [31:0]   mat_b;
    logic          arr_clr_n;
    logic [7:0]    arr_a1, arr_a2, arr_b1, arr_b2;
    logic [14:0]   c11, c12, c21, c22;
    logic [59:0]   res_c;
    logic          res_valid;
    logic          res_ready;
    logic          res_ovf;

    int n_cmp = 0;
    int n_err = 0;

    systolic_feeder_2x2 #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
        .mat_a(mat_a), .mat_b(mat_b), .arr_clr_n(arr_clr_n),
        .arr_a1(arr_a1), .arr_a2(arr_a2), .arr_b1(arr_b1), .arr_b2(arr_b2),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .res_c(res_c), .res_valid(res_valid), .res_ready(res_ready), .res_ovf(res_ovf)
    );

    always #5 clk = ~clk;

    // Behavioural systolic array: each PE accumulates and forwards a right, b down
    logic [7:0] pa11, pb11, pa21, pb12;

    function automatic logic [14:0] mul15(input logic [7:0] x, input logic [7:0] y);
        return {7'd0, x} * {7'd0, y};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst || !arr_clr_n) begin
            c11 <= '0; c12 <= '0; c21 <= '0; c22 <= '0;
            pa11 <= '0; pb11 <= '0; pa21 <= '0; pb12 <= '0;
        end else begin
            c11  <= c11 + mul15(arr_a1, arr_b1);
            c12  <= c12 + mul15(pa11, arr_b2);
            c21  <= c21 + mul15(arr_a2, pb11);
            c22  <= c22 + mul15(pa21, pb12);
            pa11 <= arr_a1;
            pb11 <= arr_b1;
            pa21 <= arr_a2;
            pb12 <= arr_b2;
        end
    end

    // Reference: C = A x B modulo 2^CW, plus exact-range overflow
    function automatic logic [59:0] ref_c(input logic [31:0] a, input logic [31:0] b);
        int ae[4];
        int be[4];
        int c[4];
        for (int i = 0; i < 4; i++) begin
            ae[i] = int'(a[31-8*i -: 8]);
            be[i] = int'(b[31-8*i -: 8]);
        end
        c[0] = ae[0]*be[0] + ae[1]*be[2];
        c[1] = ae[0]*be[1] + ae[1]*be[3];
        c[2] = ae[2]*be[0] + ae[3]*be[2];
        c[3] = ae[2]*be[1] + ae[3]*be[3];
        return {15'(c[0] % 32768), 15'(c[1] % 32768), 15'(c[2] % 32768), 15'(c[3] % 32768)};
    endfunction

    function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b);
        int ae[4];
        int be[4];
        for (int i = 0; i < 4; i++) begin
            ae[i] = int'(a[31-8*i -: 8]);
            be[i] = int'(b[31-8*i -: 8]);
        end
        return OVF_ON && ((ae[0]*be[0] + ae[1]*be[2] > 32767) || (ae[0]*be[1] + ae[1]*be[3] > 32767) ||
                          (ae[2]*be[0] + ae[3]*be[2] > 32767) || (ae[2]*be[1] + ae[3]*be[3] > 32767));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!start_ready && n < 40) begin
            tick();
            n++;
        end
        chk("start_ready_wait", {63'd0, start_ready}, 64'd1);
    endtask

    // Accept a job, check latency and result, optionally stall, then hand off
    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [59:0] exp_c,
                           input logic exp_ovf, input int hold);
        int lat;
        logic [59:0] held;
        wait_idle();
        start = 1'b1; mat_a = a; mat_b = b;
        tick();
        start = 1'b0; mat_a = $urandom; mat_b = $urandom;
        lat = 1;
        while (!res_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'd7);
        chk("res_c", {4'd0, res_c}, {4'd0, exp_c});
        chk("res_ovf", {63'd0, res_ovf}, {63'd0, exp_ovf});
        held = res_c;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", {63'd0, res_valid}, 64'd1);
            chk("hold_res_c", {4'd0, res_c}, {4'd0, held});
            chk("hold_start_ready", {63'd0, start_ready}, 64'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("post_valid", {63'd0, res_valid}, 64'd0);
        chk("post_start_ready", {63'd0, start_ready}, 64'd1);
    endtask

    typedef struct {
        logic        clr_n;
        logic [7:0]  a1, b1, a2, b2;
        logic        sr, rv;
    } cyc_t;

    typedef struct {
        logic [31:0] a, b;
        logic [59:0] c;
        logic        ovf;
        int          hold;
    } job_t;

    cyc_t        cyc_tab[7];
    job_t        job_tab[4];
    logic [31:0] ra, rb;
    int          sr_cyc[$];
    int          rv_cnt;
    int          spurious;

    initial begin
        cyc_tab[0] = '{1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0};
        cyc_tab[1] = '{1'b1, 8'd1, 8'd5, 8'd0, 8'd0, 1'b0, 1'b0};
        cyc_tab[2] = '{1'b1, 8'd2, 8'd7, 8'd3, 8'd6, 1'b0, 1'b0};
        cyc_tab[3] = '{1'b1, 8'd0, 8'd0, 8'd4, 8'd8, 1'b0, 1'b0};
        cyc_tab[4] = '{1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0};
        cyc_tab[5] = '{1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0};
        cyc_tab[6] = '{1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1};

        job_tab[0] = '{32'h01020304, 32'h05060708, {15'd19, 15'd22, 15'd43, 15'd50}, 1'b0, 0};
        job_tab[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, {15'd31746, 15'd31746, 15'd31746, 15'd31746}, OVF_ON, 2};
        job_tab[2] = '{32'h01020304, 32'h05060708, {15'd19, 15'd22, 15'd43, 15'd50}, 1'b0, 0};
        job_tab[3] = '{32'h01000001, 32'h09080706, {15'd9, 15'd8, 15'd7, 15'd6}, 1'b0, 1};

        rst = 1'b0; start = 1'b0; res_ready = 1'b0; mat_a = '0; mat_b = '0;
        tick(); tick();
        chk("rst_outputs", {22'd0, start_ready, arr_clr_n, arr_a1, arr_a2, arr_b1, arr_b2, res_valid, res_ovf},
            {22'd0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0});
        chk("rst_res_c", {4'd0, res_c}, 64'd0);
        rst = 1'b1;
        tick();

        // Cycle-exact operand schedule for the reference job
        start = 1'b1; mat_a = 32'h01020304; mat_b = 32'h05060708;
        tick();
        start = 1'b0; mat_a = 32'hDEADBEEF; mat_b = 32'hCAFEF00D;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) tick();
            chk($sformatf("cycle%0d", k + 1),
                {29'd0, arr_clr_n, arr_a1, arr_b1, arr_a2, arr_b2, start_ready, res_valid},
                {29'd0, cyc_tab[k].clr_n, cyc_tab[k].a1, cyc_tab[k].b1, cyc_tab[k].a2, cyc_tab[k].b2,
                 cyc_tab[k].sr, cyc_tab[k].rv});
        end
        chk("cyc_res_c", {4'd0, res_c}, {4'd0, 15'd19, 15'd22, 15'd43, 15'd50});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Table jobs: wrap, back-to-back without residue, short stalls
        for (int j = 0; j < 4; j++)
            run_job(job_tab[j].a, job_tab[j].b, job_tab[j].c, job_tab[j].ovf, job_tab[j].hold);

        // Randomised jobs against the arithmetic reference
        for (int j = 0; j < 20; j++) begin
            ra = $urandom; rb = $urandom;
            run_job(ra, rb, ref_c(ra, rb), ref_ovf(ra, rb), int'($urandom_range(0, 2)));
        end

        // Five-cycle stall with start asserted: result held, start ignored
        ra = 32'h0A0B0C0D; rb = 32'h01020304;
        wait_idle();
        start = 1'b1; mat_a = ra; mat_b = rb;
        tick();
        start = 1'b0;
        while (!res_valid && n_cmp < 100000) tick();
        start = 1'b1; mat_a = 32'h11111111; mat_b = 32'h22222222;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {63'd0, res_valid}, 64'd1);
            chk("stall_res_c", {4'd0, res_c}, {4'd0, ref_c(ra, rb)});
            chk("stall_start_ready", {63'd0, start_ready}, 64'd0);
        end
        start = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_valid || !start_ready) spurious++;
        end
        chk("stall_no_spurious_job", 64'(spurious), 64'd0);

        // Asynchronous reset during feed slot 1
        wait_idle();
        start = 1'b1; mat_a = 32'h05060708; mat_b = 32'h01020304;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("midjob_slot1", {48'd0, arr_a1, arr_a2}, {48'd0, 8'd6, 8'd7});
        #2 rst = 1'b0;
        #1;
        chk("midjob_rst_outputs", {22'd0, start_ready, arr_clr_n, arr_a1, arr_a2, arr_b1, arr_b2, res_valid, res_ovf},
            {22'd0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0});
        chk("midjob_rst_res_c", {4'd0, res_c}, 64'd0);
        tick();
        rst = 1'b1;
        tick();
        run_job(32'h03010402, 32'h02070108, ref_c(32'h03010402, 32'h02070108), 1'b0, 0);

        // start held high with res_ready high: one accept per job, every 8 cycles
        ra = 32'h10203040; rb = 32'h05040302;
        start = 1'b1; mat_a = ra; mat_b = rb; res_ready = 1'b1;
        rv_cnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (start_ready) sr_cyc.push_back(cyc);
            if (res_valid) begin
                rv_cnt++;
                chk("cont_res_c", {4'd0, res_c}, {4'd0, ref_c(ra, rb)});
            end
            tick();
        end
        for (int i = 1; i < sr_cyc.size(); i++)
            chk("cont_accept_spacing", 64'(sr_cyc[i] - sr_cyc[i-1]), 64'd8);
        chk("cont_jobs", 64'(rv_cnt >= 4), 64'd1);
        start = 1'b0;
        repeat (12) tick();
        res_ready = 1'b0;
        chk("cont_final_idle", {62'd0, start_ready, res_valid}, {62'd0, 1'b1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global guard against a hung run
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
